inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch initiator driving the instruction port of `RAM`. It owns the program counter, presents `instAddr` to the RAM, captures the 32-bit `instOut` response one cycle later, and buffers instructions in a small prefetch FIFO. The decode stage consumes instructions through a valid/ready handshake. A redirect input, for branches and jumps, flushes the buffer and restarts fetch.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; legal values are powers of two, 2 to 16.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `PC_STEP`, 2: PC increment per instruction, in 16-bit RAM words.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `instAddr`  out  16  address presented to `RAM.instAddr` (registered).
- `instOut`  in  32  `RAM.instOut`; valid one cycle after the address is presented.
- `redirect`  in  1  pulse requesting a fetch restart.
- `redirect_pc`  in  16  target PC; sampled when `redirect`=1.
- `inst_valid`  out  1  FIFO head holds a valid instruction.
- `inst`  out  32  instruction at the FIFO head.
- `inst_pc`  out  16  PC of `inst`.
- `inst_ready`  in  1  consumer accepts the head this cycle.
- `stall_cnt`  out  16  FIFO-full stall cycles; present only with `INST_FETCH_PERF_EN`.

## Operation
State machine:
- RESET: held while `rst`=1; the state is entered on any cycle with `rst`=1, including mid-operation.
- RUN: issues sequential fetches.
- FULL: no issue because the FIFO has no room.
- Transitions:
  - RESET→RUN on the first cycle with `rst`=0.
  - RUN→FULL when `count + inflight == DEPTH`.
  - FULL→RUN when a pop frees a slot.
  - Any state→RUN on `redirect`.

Issue rule:
- A fetch is issued in a cycle when state is RUN, `count + inflight < DEPTH`, and `redirect`=0.
- Issue sets `inflight`=1 for the next cycle, tags the request with its PC, and advances `pc` by `PC_STEP`.
- `instAddr` always shows the PC of the most recent issued request. It holds its value when no request is issued.

Response and handshake:
- Response: when `inflight`=1, `instOut` and the tagged PC are written at the FIFO tail, unless discarded (see Redirect).
- Pop: occurs when `inst_valid && inst_ready`. `inst` and `inst_pc` come from the head and are stable while `inst_valid`=1 and `inst_ready`=0.
- `inst_valid = (count != 0)`.

Redirect:
- The FIFO is emptied and any in-flight response is discarded.
- `pc` is set to `redirect_pc`, and the next issue uses it.
- Redirect wins over a simultaneous pop or push.

Boundary rules:
- PC arithmetic is modulo 2^16: 16'hFFFE + 2 = 16'h0000.
- A simultaneous push and pop in the same cycle leaves `count` unchanged.
- Pushing while full cannot occur, because the issue rule prevents it.
- Popping while empty is ignored.
- `redirect` during RESET is ignored.

Reset values:
- `instAddr`=`RESET_PC`, `pc`=`RESET_PC`
- `inst_valid`=0, `inst`=0, `inst_pc`=0
- `count`=0, `inflight`=0
- `stall_cnt`=0

## Timing
- First fetch: in cycle 0, the first cycle after `rst` falls, `instAddr`=`RESET_PC` and the request is issued. The response is captured at the end of cycle 1, and `inst_valid`=1 in cycle 2. First-instruction latency is 2 cycles.
- Steady state: with `inst_ready` held at 1 and `DEPTH`≥2, throughput is one instruction per cycle.
- Redirect latency: with `redirect` in cycle k, `inst_valid`=0 in cycle k+1 and `instAddr`=`redirect_pc` in cycle k+1. The target instruction is valid in cycle k+3.
- Backpressure: with `inst_ready`=0, at most `DEPTH` instructions are held. Issue stops in the cycle where `count + inflight` reaches `DEPTH`, and `instAddr` holds.
- Recovery: a pop in cycle n allows an issue in cycle n+1.

## Configuration
- `INST_FETCH_PERF_EN` defined: the `stall_cnt` port exists. It increments by 1 each non-reset cycle spent in FULL, saturates at 16'hFFFF, and clears on `rst`. It does not clear on `redirect`.
- `INST_FETCH_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=0, RAM preloaded with word pairs (0,1)=32'hA0A0_0001 and (2,3)=32'hA0A0_0002, `inst_ready`=1 → `instAddr` 0,2,4… on consecutive cycles; cycle 2 shows `inst`=32'hA0A0_0001 with `inst_pc`=0; cycle 3 shows `inst_pc`=2.
- `inst_ready`=0 from reset, `DEPTH`=4 → exactly 4 instructions buffered (PCs 0,2,4,6); `instAddr` holds 6; after one pop, the next `instAddr`=8.
- `redirect`=1 with `redirect_pc`=16'h0010 in cycle 5 while the FIFO holds 3 entries → cycle 6 shows `inst_valid`=0 and `instAddr`=16'h0010; cycle 8 shows `inst_pc`=16'h0010; no stale entries are ever presented.
- `redirect_pc`=16'hFFFC → `inst_pc` sequence FFFC, FFFE, 0000, 0002.
- `rst` asserted mid-stream with a full FIFO → next cycle shows `inst_valid`=0 and `instAddr`=`RESET_PC`; fetch restarts normally after release.
- With `INST_FETCH_PERF_EN`, hold `inst_ready`=0 for 20 cycles after the FIFO fills → `stall_cnt`=20; a redirect leaves it at 20; `rst` clears it to 0.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch initiator for the RAM instruction port.
// Owns the program counter, presents a registered fetch address, captures the
// RAM response one cycle later into a small prefetch FIFO, and hands
// instructions to decode over a valid/ready handshake. A redirect flushes the
// buffer, drops any in-flight response and restarts fetch at a new PC.
//
// Optional build macro:
//   INST_FETCH_PERF_EN - adds the stall_cnt port, a saturating count of
//                        cycles spent with the buffer full.
//
// DEPTH must be a power of two between 2 and 16 so the FIFO pointers can wrap
// naturally.

module inst_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] instAddr,
  input  logic [31:0] instOut,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptrT;
  typedef logic [CNT_W-1:0] cntT;

  typedef enum logic [1:0] {
    sReset,
    sRun,
    sFull
  } fetchState;

  typedef struct packed {
    logic [31:0] word;
    logic [15:0] pc;
  } fifoEntry;

  // Registered state
  fetchState   state;
  logic [15:0] pc;         // PC of the next request to issue
  logic        inflight;   // a response arrives on instOut this cycle
  logic [15:0] tagPc;      // PC of the in-flight request
  cntT         count;      // buffered instructions
  ptrT         rdPtr;
  ptrT         wrPtr;
  fifoEntry    mem [DEPTH];

  // Next-state and control
  fetchState   stateNext;
  logic [15:0] pcNext;
  cntT         countNext;
  cntT         occupancy;
  cntT         occupancyNext;
  logic        issue;
  logic        push;
  logic        pop;
  fifoEntry    head;

  assign occupancy = count + cntT'(inflight);

  // A full state means no room was predicted for this cycle; the room test is
  // kept as well so the issue rule reads exactly like its definition.
  assign issue = (state != sFull) && (occupancy < cntT'(DEPTH)) && !redirect;

  // Redirect beats both push and pop: the response in flight is dropped and
  // the head is not consumed.
  assign push = inflight && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  // Next-state computation for counters, PC and the fetch FSM.
  // NOTE: combinational logic uses blocking assignments and gives every output
  // a default first, so no latch can be inferred on an unlisted path.
  always_comb begin
    countNext = count;
    if (redirect) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + cntT'(1);
    end else if (pop && !push) begin
      countNext = count - cntT'(1);
    end

    pcNext = pc;
    if (redirect) begin
      pcNext = redirect_pc;
    end else if (issue) begin
      pcNext = pc + PC_STEP;  // wraps modulo 2^16
    end

    occupancyNext = countNext + cntT'(issue);

    stateNext = sRun;
    if (!redirect && (occupancyNext == cntT'(DEPTH))) begin
      stateNext = sFull;
    end
  end

  // Fetch FSM, PC, request tracking and FIFO bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= sReset;
      pc       <= RESET_PC;
      instAddr <= RESET_PC;
      inflight <= 1'b0;
      tagPc    <= '0;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      inflight <= issue;
      count    <= countNext;

      if (issue) begin
        tagPc <= pc;
      end

      // The address register is loaded with the PC that will be issued next
      // cycle; when the buffer is about to be full it keeps the last issued
      // address instead.
      if (stateNext != sFull) begin
        instAddr <= pcNext;
      end

      if (redirect) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (push) begin
          wrPtr <= wrPtr + ptrT'(1);
        end
        if (pop) begin
          rdPtr <= rdPtr + ptrT'(1);
        end
      end
    end
  end

  // Capture RAM responses at the FIFO tail.
  // NOTE: the storage array has no reset; count and the pointers decide what
  // is visible, and the outputs are gated while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wrPtr] <= '{word: instOut, pc: tagPc};
    end
  end

  assign head       = mem[rdPtr];
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.word : 32'h0;
  assign inst_pc    = inst_valid ? head.pc : 16'h0;

`ifdef INST_FETCH_PERF_EN
  // Saturating count of cycles spent with the buffer full; redirects do not
  // clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == sFull) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch (DEPTH=4, RESET_PC=0, PC_STEP=2).
// The RAM model returns 32'hA0A0_0000 + (addr/2) + 1 one cycle after the
// address, so word pair (0,1) holds A0A0_0001 and (2,3) holds A0A0_0002.
// Outputs are sampled and inputs driven on the falling edge; a value sampled
// on the falling edge of cycle c belongs to cycle c.

module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] instAddr;
  logic [31:0] instOut;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  inst_fetch #(
    .DEPTH   (4),
    .RESET_PC(16'h0000),
    .PC_STEP (16'd2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instAddr   (instAddr),
    .instOut    (instOut),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
`ifdef INST_FETCH_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ramWord(input logic [15:0] addr);
    return 32'hA0A0_0000 + {17'd0, addr[15:1]} + 32'd1;
  endfunction

  // Synchronous-read RAM instruction port.
  initial instOut = '0;
  always @(posedge clk) instOut <= ramWord(instAddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checkCount, errorCount);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_addr", 32'(instAddr), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", 32'(inst_pc), 32'h0);
`ifdef INST_FETCH_PERF_EN
    check("rst_stall", 32'(stall_cnt), 32'h0);
`endif

    // Streaming from reset with the consumer always ready
    rst = 1'b0; inst_ready = 1'b1;                        // cycle 0
    check("s_addr_c0", 32'(instAddr), 32'h0);
    step();                                               // cycle 1
    check("s_addr_c1", 32'(instAddr), 32'h2);
    check("s_valid_c1", 32'(inst_valid), 32'h0);
    step();                                               // cycle 2
    check("s_addr_c2", 32'(instAddr), 32'h4);
    check("s_valid_c2", 32'(inst_valid), 32'h1);
    check("s_inst_c2", inst, 32'hA0A0_0001);
    check("s_pc_c2", 32'(inst_pc), 32'h0);
    step();                                               // cycle 3
    check("s_pc_c3", 32'(inst_pc), 32'h2);
    check("s_inst_c3", inst, 32'hA0A0_0002);
    check("s_addr_c3", 32'(instAddr), 32'h6);
    step();                                               // cycle 4
    check("s_pc_c4", 32'(inst_pc), 32'h4);

    // Backpressure from reset: four instructions buffered, address holds
    rst = 1'b1; inst_ready = 1'b0;
    step();
    check("bp_rst_valid", 32'(inst_valid), 32'h0);
    rst = 1'b0;                                           // cycle 0
    check("bp_addr_c0", 32'(instAddr), 32'h0);
    repeat (3) step();                                    // cycle 3
    check("bp_addr_c3", 32'(instAddr), 32'h6);
    step();                                               // cycle 4
    check("bp_addr_c4", 32'(instAddr), 32'h6);
    repeat (2) step();                                    // cycle 6
    check("bp_addr_c6", 32'(instAddr), 32'h6);
    check("bp_pc_c6", 32'(inst_pc), 32'h0);
    check("bp_inst_c6", inst, 32'hA0A0_0001);
    inst_ready = 1'b1;                                    // single pop in cycle 6
    step();                                               // cycle 7
    check("bp_addr_c7", 32'(instAddr), 32'h8);
    check("bp_pc_c7", 32'(inst_pc), 32'h2);
    inst_ready = 1'b0;
    step();                                               // cycle 8
    check("bp_addr_c8", 32'(instAddr), 32'h8);
    step();                                               // cycle 9, buffer full

    // Reset mid-stream with a full buffer
    rst = 1'b1;
    step();
    check("mr_valid", 32'(inst_valid), 32'h0);
    check("mr_addr", 32'(instAddr), 32'h0);
    check("mr_pc", 32'(inst_pc), 32'h0);
    rst = 1'b0;                                           // cycle 0, consumer stalled
    repeat (4) step();                                    // cycle 4: 3 buffered
    check("rd_pre_valid", 32'(inst_valid), 32'h1);
    check("rd_pre_pc", 32'(inst_pc), 32'h0);

    // Redirect to 0x0010 with a simultaneous ready (redirect wins)
    redirect = 1'b1; redirect_pc = 16'h0010; inst_ready = 1'b1;
    step();                                               // k+1
    redirect = 1'b0;
    check("rd_valid_k1", 32'(inst_valid), 32'h0);
    check("rd_addr_k1", 32'(instAddr), 32'h10);
    step();                                               // k+2
    check("rd_valid_k2", 32'(inst_valid), 32'h0);
    step();                                               // k+3
    check("rd_valid_k3", 32'(inst_valid), 32'h1);
    check("rd_pc_k3", 32'(inst_pc), 32'h10);
    check("rd_inst_k3", inst, 32'hA0A0_0009);
    step();                                               // k+4
    check("rd_pc_k4", 32'(inst_pc), 32'h12);

    // Redirect near the top of the address space: PC wraps
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect = 1'b0;
    check("wr_valid_k1", 32'(inst_valid), 32'h0);
    check("wr_addr_k1", 32'(instAddr), 32'hFFFC);
    step();
    check("wr_addr_k2", 32'(instAddr), 32'hFFFE);
    step();
    check("wr_pc_0", 32'(inst_pc), 32'hFFFC);
    check("wr_inst_0", inst, 32'hA0A0_7FFF);
    check("wr_addr_k3", 32'(instAddr), 32'h0);
    step();
    check("wr_pc_1", 32'(inst_pc), 32'hFFFE);
    step();
    check("wr_pc_2", 32'(inst_pc), 32'h0);
    check("wr_inst_2", inst, 32'hA0A0_0001);
    step();
    check("wr_pc_3", 32'(inst_pc), 32'h2);

`ifdef INST_FETCH_PERF_EN
    // Stall counter: full from cycle 4; cycles 4..23 stay full (20 cycles),
    // with the pop in cycle 23 returning to RUN in cycle 24.
    rst = 1'b1; inst_ready = 1'b0;
    step();
    rst = 1'b0;                                           // cycle 0
    repeat (23) step();                                   // cycle 23
    check("pf_stall_c23", 32'(stall_cnt), 32'd19);
    inst_ready = 1'b1;
    step();                                               // cycle 24, RUN
    check("pf_stall_c24", 32'(stall_cnt), 32'd20);
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
    step();                                               // cycle 25
    redirect = 1'b0;
    check("pf_stall_redirect", 32'(stall_cnt), 32'd20);
    check("pf_addr_redirect", 32'(instAddr), 32'h40);
    rst = 1'b1;
    step();
    check("pf_stall_rst", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
